// File: rtl/ws2812_rx.sv
// ws2812_rx -- WS2812 serial line receiver.
//
// Decodes the single-wire WS2812 protocol by timing the high phase of each
// pulse. A pulse longer than T_THRESH cycles is a 1, otherwise a 0. Every 24
// bits form one word, which is presented on rgb_data/led_num with a one-cycle
// write strobe. A low gap of T_RESET cycles ends a frame.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   din        in   WS2812 serial line (asynchronous to clk)
//   rgb_data   out  [23:0] last decoded word, first received bit in bit 23
//   led_num    out  [7:0]  word index of rgb_data within the current frame
//   write      out  one-cycle strobe, rgb_data/led_num valid
//   frame_done out  one-cycle strobe, reset gap seen after at least one bit
//   error      out  one-cycle strobe, protocol violation
//   overflow   out  level, more than NUM_LEDS words in the current frame
//
// Handshake: there is no back-pressure. write is a pure valid strobe; the
// consumer must take rgb_data/led_num in the cycle write is high. Both hold
// their values until the next write.
//
// The FSM state is held in state_q (SYNC/LOW/HIGH) for external checkers.

module ws2812_rx #(
  parameter int NUM_LEDS   = 8,
  parameter int T_THRESH   = 7,
  parameter int T_MAX_HIGH = 20,
  parameter int T_RESET    = 600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done,
  output logic        error,
  output logic        overflow
);

  localparam int LCW = $clog2(T_RESET + 1);
  localparam int HCW = $clog2(T_MAX_HIGH + 1);
  localparam int WCW = $clog2(NUM_LEDS + 1);

  localparam logic [LCW-1:0] T_RESET_W  = LCW'(T_RESET);
  localparam logic [LCW-1:0] T_RESET_M1 = LCW'(T_RESET - 1);
  localparam logic [HCW-1:0] T_MAX_W    = HCW'(T_MAX_HIGH);
  localparam logic [HCW-1:0] T_MAX_M1   = HCW'(T_MAX_HIGH - 1);
  localparam logic [HCW-1:0] T_THRESH_W = HCW'(T_THRESH);
  localparam logic [WCW-1:0] NUM_LEDS_W = WCW'(NUM_LEDS);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           din_m, din_s;
  logic [LCW-1:0] low_cnt_q, low_cnt_d;
  logic [HCW-1:0] high_cnt_q, high_cnt_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]    shift_q, shift_d;
  logic [23:0]    rgb_d;
  logic [7:0]     led_d;
  logic           write_d, frame_done_d, error_d, overflow_d;

  logic [LCW-1:0] low_inc;
  logic [HCW-1:0] high_inc;
  logic           gap_hit;
  logic           max_hit;
  logic           bit_val;
  logic [4:0]     bit_idx;

  // Saturating increments: the counters stop at their terminal value so a
  // long idle line or stuck-high line never wraps back into a valid range.
  assign low_inc  = (low_cnt_q == T_RESET_W) ? low_cnt_q : low_cnt_q + LCW'(1);
  assign high_inc = (high_cnt_q == T_MAX_W) ? high_cnt_q : high_cnt_q + HCW'(1);

  // Both events fire on the cycle the counter steps onto its terminal value,
  // so each fires once per gap / per stuck pulse.
  assign gap_hit = !din_s && (low_cnt_q == T_RESET_M1);
  assign max_hit = din_s && (high_cnt_q == T_MAX_M1);

  assign bit_val = (high_cnt_q > T_THRESH_W);
  // Bits are placed from bit 23 downwards, so the first received bit lands
  // in the MSB once the word is complete.
  assign bit_idx = 5'd23 - bit_cnt_q;

  // Two-flop synchronizer; din_s is the only version of din used below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      write      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      rgb_data   <= rgb_d;
      led_num    <= led_d;
      write      <= write_d;
      frame_done <= frame_done_d;
      error      <= error_d;
      overflow   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    rgb_d        = rgb_data;
    led_d        = led_num;
    write_d      = 1'b0;
    frame_done_d = 1'b0;
    error_d      = 1'b0;
    overflow_d   = overflow;

    case (state_q)
      // Wait for a full reset gap before trusting any pulse timing.
      SYNC: begin
        if (din_s) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_inc;
          if (gap_hit) begin
            state_d    = LOW;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            overflow_d = 1'b0;
          end
        end
      end

      LOW: begin
        if (din_s) begin
          state_d    = HIGH;
          high_cnt_d = HCW'(1);
        end else begin
          low_cnt_d = low_inc;
          if (gap_hit) begin
            frame_done_d = (bit_cnt_q != '0) || (word_cnt_q != '0);
            error_d      = (bit_cnt_q != '0);
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
            overflow_d   = 1'b0;
          end
        end
      end

      HIGH: begin
        if (din_s) begin
          high_cnt_d = high_inc;
          if (max_hit) begin
            // Stuck or overlong high: abandon the word and resynchronise.
            error_d   = 1'b1;
            bit_cnt_d = '0;
            low_cnt_d = '0;
            state_d   = SYNC;
          end
        end else begin
          shift_d[bit_idx] = bit_val;
          low_cnt_d        = LCW'(1);
          state_d          = LOW;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (word_cnt_q < NUM_LEDS_W) begin
              write_d    = 1'b1;
              rgb_d      = shift_d;
              led_d      = 8'(word_cnt_q);
              word_cnt_d = word_cnt_q + WCW'(1);
            end else begin
              overflow_d = 1'b1;
              word_cnt_d = NUM_LEDS_W;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

endmodule
